// File: rtl/dma_axi_pkg.sv
// Shared FSM state encoding, AXI read-channel constants and the arsize helper.
// Purely declarative: no logic, no latency, no flow control of its own.
package dma_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // Beat size code is log2 of the bytes per beat.
  function automatic logic [2:0] arsize_f(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/rd_beat_fifo.sv
// Show-ahead beat FIFO; a push at edge t is at the head after edge t.
// Push is dropped when full and pop when empty; the caller gates push with !full.
module rd_beat_fifo #(
  parameter int WIDTH = 513,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head_dat
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/dma_rd_master.sv
// AXI4 read master: one request -> one INCR burst; R beats land in a show-ahead FIFO.
// Ack one cycle after request, arvalid one cycle later; rready drops on registered FIFO full.
module dma_rd_master
  import dma_axi_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int FIFO_DEPTH         = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rd_req,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] rd_addr,
  input  logic [7:0]                    rd_len,
  output logic                          rd_req_ack,
  output logic [C_M_AXI_DATA_WIDTH-1:0] rd_data,
  output logic                          rd_data_valid,
  output logic                          rd_data_last,
  input  logic                          rd_data_taken,
  output logic                          rd_error,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);
  localparam int BEAT_W = C_M_AXI_DATA_WIDTH + 1;

  state_e                          state_q, state_d;
  logic                            ack_q, ack_d;
  logic                            arvalid_q, arvalid_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [7:0]                      arlen_q, arlen_d;
  logic                            err_q, err_d;
  logic                            r_acc;
  logic                            fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]     fifo_cnt;
  logic [BEAT_W-1:0]               fifo_head;

  assign m_axi_rready  = (state_q == ST_DATA) && !fifo_full;
  assign r_acc         = m_axi_rvalid && m_axi_rready;
  assign m_axi_arsize  = arsize_f(C_M_AXI_DATA_WIDTH);
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign rd_req_ack    = ack_q;
  assign rd_error      = err_q;
  assign rd_data_valid = (fifo_cnt != '0);
  // Stale RAM contents never leak out while the FIFO is empty.
  assign {rd_data, rd_data_last} = fifo_empty ? '0 : fifo_head;

  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    err_d     = err_q || (r_acc && (m_axi_rresp != RESP_OKAY));
    case (state_q)
      ST_IDLE: begin
        if (rd_req) begin
          ack_d    = 1'b1;
          araddr_d = rd_addr;
          arlen_d  = rd_len;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        // First ADDR cycle is the ack cycle; arvalid follows one cycle later.
        if (!arvalid_q) begin
          arvalid_d = 1'b1;
        end else if (m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_acc && m_axi_rlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ack_q     <= 1'b0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      err_q     <= err_d;
    end
  end

  rd_beat_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (r_acc),
    .push_dat ({m_axi_rdata, m_axi_rlast}),
    .pop      (rd_data_taken),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt),
    .head_dat (fifo_head)
  );

endmodule

// File: tb/tb_dma_rd_master.sv
// Directed bench for dma_rd_master: drives AR/R and the consumer side by hand.
module tb_dma_rd_master;
  localparam int AW = 64;
  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_len;
  logic          rd_req_ack;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic          rd_data_last;
  logic          rd_data_taken;
  logic          rd_error;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast;
  logic          m_axi_rvalid;
  logic          m_axi_rready;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  dma_rd_master #(
    .C_M_AXI_ADDR_WIDTH (AW),
    .C_M_AXI_DATA_WIDTH (DW),
    .FIFO_DEPTH         (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_len        (rd_len),
    .rd_req_ack    (rd_req_ack),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .rd_data_last  (rd_data_last),
    .rd_data_taken (rd_data_taken),
    .rd_error      (rd_error),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Request handshake plus AR phase with ar_wait cycles of arready=0.
  task automatic do_req(input logic [AW-1:0] a, input logic [7:0] l, input int ar_wait);
    rd_req = 1'b1; rd_addr = a; rd_len = l;
    tick();
    chk("ack_pulse", rd_req_ack, 1);
    chk("arvalid_not_with_ack", m_axi_arvalid, 0);
    rd_req = 1'b0;
    tick();
    chk("ack_cleared", rd_req_ack, 0);
    chk("arvalid_up", m_axi_arvalid, 1);
    chk("araddr", m_axi_araddr, a);
    chk("arlen", m_axi_arlen, l);
    for (int i = 0; i < ar_wait; i++) begin
      tick();
      chk("ar_hold_valid", m_axi_arvalid, 1);
      chk("ar_hold_addr", m_axi_araddr, a);
      chk("ar_hold_len", m_axi_arlen, l);
    end
    m_axi_arready = 1'b1;
    tick();
    m_axi_arready = 1'b0;
    chk("arvalid_dropped", m_axi_arvalid, 0);
    chk("rready_in_data", m_axi_rready, 1);
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic last, input logic [1:0] resp);
    int w;
    w = 0;
    m_axi_rvalid = 1'b1; m_axi_rdata = d; m_axi_rlast = last; m_axi_rresp = resp;
    while (!m_axi_rready && w < 20) begin
      tick();
      w++;
    end
    chk("rready_wait", m_axi_rready, 1);
    tick();
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
  endtask

  task automatic take_beat(input logic [DW-1:0] d, input logic last);
    chk("take_valid", rd_data_valid, 1);
    chk("take_data", rd_data, d);
    chk("take_last", rd_data_last, last);
    rd_data_taken = 1'b1;
    tick();
    rd_data_taken = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench timeout");
  end

  initial begin
    int sent;
    int rcvd;
    logic acc;
    logic popd;

    rst_n = 1'b0; rd_req = 1'b0; rd_addr = '0; rd_len = '0; rd_data_taken = 1'b0;
    m_axi_arready = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
    m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
    tick(); tick();
    chk("rst_ack", rd_req_ack, 0);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_rready", m_axi_rready, 0);
    chk("rst_valid", rd_data_valid, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_error", rd_error, 0);
    chk("rst_arsize", m_axi_arsize, 6);
    chk("rst_arburst", m_axi_arburst, 1);
    rst_n = 1'b1;
    tick();
    chk("idle_no_ack", rd_req_ack, 0);

    // Single burst of four beats.
    do_req(64'h1000, 8'd3, 0);
    chk("t1_arsize", m_axi_arsize, 6);
    chk("t1_arburst", m_axi_arburst, 1);
    send_beat(512'hA0, 1'b0, 2'b00);
    chk("t1_visible_valid", rd_data_valid, 1);
    chk("t1_visible_data", rd_data, 512'hA0);
    send_beat(512'hA1, 1'b0, 2'b00);
    send_beat(512'hA2, 1'b0, 2'b00);
    send_beat(512'hA3, 1'b1, 2'b00);
    chk("t1_idle_rready", m_axi_rready, 0);
    take_beat(512'hA0, 1'b0);
    take_beat(512'hA1, 1'b0);
    take_beat(512'hA2, 1'b0);
    take_beat(512'hA3, 1'b1);
    chk("t1_drained", rd_data_valid, 0);

    // AR backpressure for five cycles, then no second handshake.
    do_req(64'h2000, 8'd0, 5);
    m_axi_arready = 1'b1;
    tick();
    chk("t2_no_second_ar", m_axi_arvalid, 0);
    tick();
    chk("t2_no_second_ar2", m_axi_arvalid, 0);
    m_axi_arready = 1'b0;
    send_beat(512'h2B, 1'b1, 2'b00);
    take_beat(512'h2B, 1'b1);

    // FIFO full: 32-beat burst with no consumer until rready drops.
    do_req(64'h3000, 8'd31, 0);
    sent = 0;
    m_axi_rvalid = 1'b1; m_axi_rdata = '0; m_axi_rlast = 1'b0;
    for (int c = 0; c < 40 && m_axi_rready; c++) begin
      tick();
      sent++;
      m_axi_rdata = DW'(sent);
      m_axi_rlast = (sent == 31);
    end
    chk("t3_fill_count", sent, 16);
    chk("t3_rready_low", m_axi_rready, 0);
    tick();
    chk("t3_still_low", m_axi_rready, 0);
    chk("t3_head", rd_data, 0);
    rd_data_taken = 1'b1;
    chk("t3_pop_same_cycle_rready", m_axi_rready, 0);
    rcvd = 0;
    for (int c = 0; c < 200 && rcvd < 32; c++) begin
      if (rd_data_valid) begin
        chk("t3_data", rd_data, DW'(rcvd));
        chk("t3_last", rd_data_last, (rcvd == 31));
      end
      acc  = m_axi_rvalid && m_axi_rready;
      popd = rd_data_valid;
      tick();
      if (acc) sent++;
      if (popd) rcvd++;
      m_axi_rvalid = (sent < 32);
      m_axi_rdata  = DW'(sent);
      m_axi_rlast  = (sent == 31);
    end
    rd_data_taken = 1'b0;
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    chk("t3_sent", sent, 32);
    chk("t3_rcvd", rcvd, 32);
    chk("t3_empty", rd_data_valid, 0);

    // Back-to-back: request held high across the first burst.
    rd_req = 1'b1; rd_addr = 64'h4000; rd_len = 8'd1;
    tick();
    chk("t4_ack1", rd_req_ack, 1);
    rd_addr = 64'h5000;
    tick();
    chk("t4_ack1_clear", rd_req_ack, 0);
    chk("t4_araddr1", m_axi_araddr, 64'h4000);
    m_axi_arready = 1'b1;
    tick();
    m_axi_arready = 1'b0;
    send_beat(512'h40, 1'b0, 2'b00);
    chk("t4_no_ack_mid", rd_req_ack, 0);
    send_beat(512'h41, 1'b1, 2'b00);
    chk("t4_no_early_ack", rd_req_ack, 0);
    tick();
    chk("t4_ack2", rd_req_ack, 1);
    rd_req = 1'b0;
    tick();
    chk("t4_arvalid2", m_axi_arvalid, 1);
    chk("t4_araddr2", m_axi_araddr, 64'h5000);
    chk("t4_arlen2", m_axi_arlen, 1);
    m_axi_arready = 1'b1;
    tick();
    m_axi_arready = 1'b0;
    send_beat(512'h50, 1'b0, 2'b00);
    send_beat(512'h51, 1'b1, 2'b00);
    take_beat(512'h40, 1'b0);
    take_beat(512'h41, 1'b1);
    take_beat(512'h50, 1'b0);
    take_beat(512'h51, 1'b1);

    // Error response is sticky and the data still arrives.
    do_req(64'h6000, 8'd1, 0);
    send_beat(512'h60, 1'b0, 2'b00);
    chk("t5_err_clear", rd_error, 0);
    send_beat(512'h61, 1'b1, 2'b10);
    chk("t5_err_set", rd_error, 1);
    take_beat(512'h60, 1'b0);
    take_beat(512'h61, 1'b1);
    tick();
    chk("t5_err_sticky", rd_error, 1);

    // Reset in the middle of an eight-beat burst.
    do_req(64'h7000, 8'd7, 0);
    send_beat(512'h70, 1'b0, 2'b00);
    send_beat(512'h71, 1'b0, 2'b00);
    chk("t6_pre_valid", rd_data_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_valid", rd_data_valid, 0);
    chk("t6_data", rd_data, 0);
    chk("t6_last", rd_data_last, 0);
    chk("t6_rready", m_axi_rready, 0);
    chk("t6_arvalid", m_axi_arvalid, 0);
    chk("t6_araddr", m_axi_araddr, 0);
    chk("t6_arlen", m_axi_arlen, 0);
    chk("t6_error", rd_error, 0);
    chk("t6_ack", rd_req_ack, 0);
    tick();
    rst_n = 1'b1;
    tick();
    do_req(64'h8000, 8'd0, 2);
    send_beat(512'h80, 1'b1, 2'b00);
    take_beat(512'h80, 1'b1);
    chk("t6_final_empty", rd_data_valid, 0);
    chk("t6_final_err", rd_error, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
